// File: rtl/xmit_pkg.sv
// xmit_pkg: shared state encoding, control-word layout and LFSR constants for the xmit frame generator.
package xmit_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HEAD = 3'd1;
   localparam logic [2:0] ST_BODY = 3'd2;
   localparam logic [2:0] ST_TAIL = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;
   localparam logic [2:0] ST_FIN  = 3'd5;
   localparam int CTRL_FIELDS = 2;
   localparam int CTRL_LO_OFS = 0;
   localparam logic [7:0] LFSR_SEED = 8'h01;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/xmit_lfsr8.sv
// xmit_lfsr8: 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), right-shifting, reloadable to the seed.
module xmit_lfsr8 import xmit_pkg::*; (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       enable,
   input  logic       load,
   output logic [7:0] q
);
   always_ff @(posedge clk_sys)
      if (reset || load) q <= LFSR_SEED;
      else if (enable) q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 8'h00);
endmodule

// File: rtl/xmit_pkt_gen.sv
// xmit_pkt_gen: configurable head/body/tail frame source for the xmitTop receive interface.
// Define XMIT_PKT_GEN_PRBS_EN to fill frame bodies from an 8-bit LFSR instead of BODY_VAL.
module xmit_pkt_gen import xmit_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int LEN_W = 12,
   parameter int CNT_W = 16,
   parameter int MARK_BYTES = 4,
   parameter logic [DATA_W-1:0] MARK_VAL = 8'hFF,
   parameter logic [DATA_W-1:0] BODY_VAL = 8'h00
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 pause,
   input  logic [LEN_W-1:0]     cfg_len,
   input  logic [CNT_W-1:0]     cfg_num_pkts,
   input  logic [LEN_W-1:0]     cfg_gap,
   input  logic                 cfg_hi_priority,
   output logic [DATA_W-1:0]    f_data_out,
   output logic                 f_data_valid,
   output logic                 f_frame_valid,
   output logic [2*LEN_W-1:0]   f_ctrl_out,
   output logic                 f_hi_priority,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     pkt_count
);
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2*MARK_BYTES+1);
   localparam logic [LEN_W-1:0] MARK_LAST = LEN_W'(MARK_BYTES-1);
   logic [2:0] state;
   logic [LEN_W-1:0] cyc, len_q, gap_q, body_last;
   logic [CNT_W-1:0] num_q;
   logic prio_q, phase_end, last_pkt, active;
   logic [DATA_W-1:0] body_byte;
   assign body_last = len_q - MIN_LEN;
   assign phase_end = state == ST_BODY ? cyc == body_last :
                      state == ST_GAP  ? cyc == gap_q - LEN_W'(1) : cyc == MARK_LAST;
   assign last_pkt = pkt_count + CNT_W'(1) == num_q;
   always_ff @(posedge clk_sys)
      if (reset) begin
         state <= ST_IDLE;
         cyc <= '0;
         len_q <= '0;
         gap_q <= '0;
         num_q <= '0;
         prio_q <= 1'b0;
         pkt_count <= '0;
      end else if (state == ST_IDLE) begin
         if (start) begin
            len_q <= cfg_len < MIN_LEN ? MIN_LEN : cfg_len;
            gap_q <= cfg_gap;
            num_q <= cfg_num_pkts;
            prio_q <= cfg_hi_priority;
            pkt_count <= '0;
            cyc <= '0;
            state <= cfg_num_pkts == '0 ? ST_FIN : ST_HEAD;
         end
      end else if (state == ST_FIN) begin
         state <= ST_IDLE;
      end else if (!pause && phase_end) begin
         cyc <= '0;
         pkt_count <= state == ST_TAIL ? pkt_count + CNT_W'(1) : pkt_count;
         state <= state == ST_HEAD ? ST_BODY :
                  state == ST_BODY ? ST_TAIL :
                  state == ST_GAP  ? ST_HEAD :
                  last_pkt         ? ST_FIN  :
                  gap_q == '0      ? ST_HEAD : ST_GAP;
      end else if (!pause) begin
         cyc <= cyc + LEN_W'(1);
      end
`ifdef XMIT_PKT_GEN_PRBS_EN
   logic [7:0] lfsr_q;
   xmit_lfsr8 u_lfsr (
      .clk_sys(clk_sys),
      .reset(reset),
      .enable(state == ST_BODY && !pause),
      .load(state == ST_IDLE && start),
      .q(lfsr_q)
   );
   assign body_byte = DATA_W'(lfsr_q);
`else
   assign body_byte = BODY_VAL;
`endif
   // pause masks the byte stream combinationally, so a held first HEAD cycle re-emits its strobe later
   assign active = (state == ST_HEAD || state == ST_BODY || state == ST_TAIL) && !pause;
   assign busy = state != ST_IDLE;
   assign done = state == ST_FIN;
   assign f_data_valid = active;
   assign f_frame_valid = active && state == ST_HEAD && cyc == '0;
   assign f_ctrl_out = f_frame_valid ? {CTRL_FIELDS{len_q}} : '0;
   assign f_data_out = !active ? '0 : state == ST_BODY ? body_byte : MARK_VAL;
   assign f_hi_priority = busy && prio_q;
endmodule
